div_iter_unit: RTL and testbench
================================

DIV_ITER_UNIT -- requirements
Module: div_iter_unit

Interface
REQ-001 The block SHALL have one parameter: DW, default 32, operand width in bits.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the sole clock.
REQ-003 The block SHALL have port rst  input  1  synchronous active-high reset; it is also driven high for a pipeline flush.
REQ-004 The block SHALL have port a  input  DW  dividend.
REQ-005 The block SHALL have port b  input  DW  divisor.
REQ-006 The block SHALL have port sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-007 The block SHALL have port opn_valid  input  1  master holds operands valid.
REQ-008 The block SHALL have port res_ready  input  1  master can take the result this cycle.
REQ-009 The block SHALL have port res_valid  output  1  result available and stable.
REQ-010 The block SHALL have port result  output  2*DW  {remainder, quotient}; the upper half goes to hi and the lower half to lo.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE -> CALC -> DONE -> IDLE.
REQ-012 In IDLE with opn_valid=1, the block SHALL, on the next edge (the accept edge), latch |a|, |b|, sign, the sign of a and the sign of b, clear the iteration counter and the partial remainder, and enter CALC.
REQ-013 The block SHALL take magnitudes only when sign=1 and the operand MSB=1; all other cases are used as-is.
REQ-014 In CALC, the block SHALL perform one restoring shift-subtract step per cycle, DW steps in total, and SHALL ignore changes on a, b and sign.
REQ-015 On the DW-th CALC edge, the block SHALL register the sign-corrected result and enter DONE, so res_valid is first high after accept edge + DW edges (32 for DW=32).
REQ-016 Sign correction SHALL negate the quotient when the latched signs of a and b differ, and SHALL negate the remainder when the dividend was negative (signed mode only).
REQ-017 The block SHALL drive res_valid = 1 only in DONE, and result SHALL be held constant while in DONE.
REQ-018 In DONE with res_ready=1, the block SHALL transfer the result on that edge and return to IDLE; res_valid is low the following cycle.
REQ-019 A new operation SHALL be accepted no earlier than the cycle after returning to IDLE; back-to-back divides are therefore separated by one IDLE cycle.
REQ-020 In DONE with res_ready=0, the block SHALL remain in DONE indefinitely (stall) with result unchanged.
REQ-021 If opn_valid=0 in CALC or DONE, the block SHALL abort to IDLE on the next edge; res_valid is low thereafter and result retains its last value.
REQ-022 For b=0, the block SHALL return quotient = all ones and remainder = a (the raw input); this is not an error.
REQ-023 For signed 0x80000000 / 0xFFFFFFFF, the block SHALL return quotient 0x80000000 and remainder 0.
REQ-024 When rst=1 in the same cycle as any other event, rst SHALL take priority.

Reset
REQ-025 When rst=1 at an edge, the block SHALL force state=IDLE, counter=0, result=0, partial remainder=0 and latched operands=0; res_valid is 0 from the next cycle.
REQ-026 Reset in the middle of CALC or DONE SHALL discard the operation with no residual effect; the next accept SHALL behave as from power-up.

Structure
REQ-027 Package div_pkg SHALL hold the FSM state encoding (IDLE/CALC/DONE), the default DW = 32, and the counter width CNT_W = 6.
REQ-028 The single combinational step SHALL be in sub-module div_step (inputs: partial remainder, next dividend bit, divisor; outputs: new remainder, quotient bit), instantiated once.
REQ-029 The implementation SHALL contain no other sub-modules, no multipliers and no latches.

Verification
REQ-030 The bench SHALL cover: unsigned a=100, b=7, sign=0, res_ready=1 -> res_valid 32 cycles after accept, result = {0x00000002, 0x0000000E}, res_valid low next cycle.
REQ-031 The bench SHALL cover: signed a=-7 (0xFFFFFFF9), b=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed a=7, b=-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-032 The bench SHALL cover: b=0, a=0x12345678, either sign -> result {0x12345678, 0xFFFFFFFF}; also signed 0x80000000 / -1 -> {0, 0x80000000}.
REQ-033 The bench SHALL cover: res_ready held 0 for 5 cycles in DONE -> res_valid and result stable for all 5 cycles; transfer on the first res_ready=1 edge.
REQ-034 The bench SHALL cover: rst pulsed at iteration 10, then a new op 50/5 -> result {0, 10} with full latency and no stale data; opn_valid dropped at iteration 20 -> IDLE next cycle, res_valid never asserted.
REQ-035 The bench SHALL cover: 1000 random signed and unsigned ops with random res_ready backpressure, compared against a reference model, with res_valid never high outside DONE.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW-1:0] rem_o,
  output logic          q_o
);

  logic [DW:0] shifted;
  logic [DW:0] diff;

  // Trial subtraction; bit DW of diff is the borrow since rem_i < divisor.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvs_i};
    q_o     = ~diff[DW];
    rem_o   = q_o ? diff[DW-1:0] : shifted[DW-1:0];
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative signed/unsigned divider, one quotient bit per cycle.
// result = {remainder, quotient}.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sign,
  input  logic          opn_valid,
  input  logic          res_ready,
  output logic          res_valid,
  output logic [2*DW-1:0] result
);

  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DW - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      rem_q, rem_d;     // partial remainder
  logic [DW-1:0]      dvd_q, dvd_d;     // |a|, quotient bits shift in at the LSB
  logic [DW-1:0]      dvs_q, dvs_d;     // |b|
  logic               sign_q, sign_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [2*DW-1:0]    result_q, result_d;

  logic [DW-1:0]      step_rem;
  logic               step_q;
  logic [DW-1:0]      q_raw, q_fix, r_fix;
  logic               a_neg, b_neg;

  div_step #(.DW(DW)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[DW-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Sign correction of the final step; a zero divisor keeps an all-ones
  // quotient and the remainder negation restores the raw dividend.
  always_comb begin
    q_raw = {dvd_q[DW-2:0], step_q};
    if (dvs_q == '0)
      q_fix = '1;
    else if (sign_q && (a_msb_q ^ b_msb_q))
      q_fix = -q_raw;
    else
      q_fix = q_raw;
    r_fix = (sign_q && a_msb_q) ? -step_rem : step_rem;
  end

  // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sign_d   = sign_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    result_d = result_q;
    a_neg    = sign & a[DW-1];
    b_neg    = sign & b[DW-1];
    case (state_q)
      IDLE: begin
        if (opn_valid) begin
          dvd_d   = a_neg ? -a : a;
          dvs_d   = b_neg ? -b : b;
          sign_d  = sign;
          a_msb_d = a[DW-1];
          b_msb_d = b[DW-1];
          cnt_d   = '0;
          rem_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!opn_valid) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = q_raw;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IT) begin
            result_d = {r_fix, q_fix};
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (!opn_valid || res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears everything so a flushed op leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sign_q   <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sign_q   <= sign_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      result_q <= result_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit against a plain-arithmetic model.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        sign = 1'b0;
  logic        opn_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic        res_valid;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  div_iter_unit #(.DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .sign      (sign),
    .opn_valid (opn_valid),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Reference: {remainder, quotient} using SV integer division semantics.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    int sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sx = int'(x); sy = int'(y);
      q = sx / sy; r = sx % sy;
      return {32'(r), 32'(q)};
    end
    return {x % y, x / y};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive an op from IDLE and wait for res_valid; lat counts edges after accept.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                       output logic [63:0] res, output int lat);
    a = x; b = y; sign = s; opn_valid = 1'b1;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (res_valid) begin lat = n - 1; break; end
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", res_valid); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    rst = 1'b0; tick();
  endtask

  task automatic test_unsigned_basic();
    logic [63:0] r; int lat;
    res_ready = 1'b1;
    do_op(32'd100, 32'd7, 1'b0, r, lat);
    checks++; if (lat != 32) begin errors++; $display("FAIL basic_latency got %0d want 32", lat); end
    checks++; if (r !== {32'h2, 32'hE}) begin errors++; $display("FAIL basic_result got %h want %h", r, {32'h2, 32'hE}); end
    tick(); opn_valid = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", res_valid); end
    tick();
  endtask

  task automatic test_signed();
    logic [63:0] r; int lat;
    res_ready = 1'b1;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, r, lat);
    checks++; if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL signed_m7_2 got %h want ffffffff_fffffffd", r); end
    tick(); opn_valid = 1'b0; tick();
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, r, lat);
    checks++; if (r !== {32'h1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL signed_7_m2 got %h want 00000001_fffffffd", r); end
    tick(); opn_valid = 1'b0; tick();
  endtask

  task automatic test_boundary();
    logic [63:0] r; int lat;
    res_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      do_op(32'h1234_5678, 32'd0, 1'(s), r, lat);
      checks++; if (r !== {32'h1234_5678, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div_by_zero sign=%0d got %h want 12345678_ffffffff", s, r); end
      tick(); opn_valid = 1'b0; tick();
    end
    do_op(32'hF000_0000, 32'd0, 1'b1, r, lat);
    checks++; if (r !== {32'hF000_0000, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div_by_zero_neg got %h want f0000000_ffffffff", r); end
    tick(); opn_valid = 1'b0; tick();
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat);
    checks++; if (r !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL overflow got %h want 00000000_80000000", r); end
    tick(); opn_valid = 1'b0; tick();
  endtask

  task automatic test_stall();
    logic [63:0] r, exp; int lat;
    logic [31:0] x, y;
    x = $urandom; y = $urandom_range(1, 1000);
    exp = ref_div(x, y, 1'b1);
    res_ready = 1'b0;
    do_op(x, y, 1'b1, r, lat);
    checks++; if (r !== exp) begin errors++; $display("FAIL stall_result got %h want %h", r, exp); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (res_valid !== 1'b1 || result !== exp) begin
        errors++; $display("FAIL stall_hold cyc=%0d valid=%b result=%h want 1 %h", k, res_valid, result, exp);
      end
    end
    res_ready = 1'b1; tick(); opn_valid = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_transfer got %b want 0", res_valid); end
    res_ready = 1'b0; tick();
  endtask

  task automatic test_flush_abort();
    logic [63:0] r; int lat;
    // reset flush at iteration 10
    a = 32'hDEAD_BEEF; b = 32'd3; sign = 1'b0; opn_valid = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1; opn_valid = 1'b0; tick(); rst = 1'b0;
    checks++; if (res_valid !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL flush_state valid=%b result=%h want 0 0", res_valid, result);
    end
    tick();
    do_op(32'd50, 32'd5, 1'b0, r, lat);
    checks++; if (lat != 32) begin errors++; $display("FAIL flush_latency got %0d want 32", lat); end
    checks++; if (r !== {32'd0, 32'd10}) begin errors++; $display("FAIL flush_result got %h want 0_a", r); end
    res_ready = 1'b1; tick(); opn_valid = 1'b0; res_ready = 1'b0; tick();
    // abort by dropping opn_valid at iteration 20
    a = 32'd999; b = 32'd4; opn_valid = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) tick();
    opn_valid = 1'b0; tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", res_valid); end
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin tick(); if (res_valid) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_valid got %0d valid cycles want 0", seen); end
    end
    checks++; if (result !== {32'd0, 32'd10}) begin errors++; $display("FAIL abort_result_kept got %h want 0_a", result); end
  endtask

  task automatic test_random();
    logic [31:0] x, y; logic s; logic [63:0] exp;
    bit seen, done;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      x = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      s = 1'($urandom_range(0, 1));
      exp = ref_div(x, y, s);
      a = x; b = y; sign = s; opn_valid = 1'b1;
      seen = 0; done = 0;
      for (int n = 1; n <= 300 && !done; n++) begin
        res_ready = 1'($urandom_range(0, 1));
        tick();
        a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
        if (res_valid) begin
          if (!seen) begin
            checks++; if (n != 33) begin errors++; $display("FAIL rand_latency op=%0d got %0d want 32", i, n - 1); end
          end
          checks++; if (result !== exp) begin
            errors++; $display("FAIL rand_result op=%0d a=%h b=%h s=%b got %h want %h", i, x, y, s, result, exp);
          end
          seen = 1;
        end else if (seen) begin
          done = 1;
        end
      end
      checks++; if (!done) begin errors++; $display("FAIL rand_timeout op=%0d", i); end
    end
    opn_valid = 1'b0; res_ready = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_boundary();
    test_stall();
    test_flush_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
